// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: FSM state encoding and access-size codes.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    HOLD     = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: load lane select/extension, store strobes and data replication.
module mem_lane_align #(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [3:0]        wstrb
);
  import mem_stage_pkg::*;

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata[7:0];
    case (addr_lo)
      2'd1:    sel_byte = rdata[15:8];
      2'd2:    sel_byte = rdata[23:16];
      2'd3:    sel_byte = rdata[31:24];
      default: sel_byte = rdata[7:0];
    endcase
    sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Unknown size code 3 is handled as a full word.
  always_comb begin
    load_data = rdata;
    wdata_rep = wdata;
    wstrb     = 4'b1111;
    case (size)
      SZ_BYTE: begin
        load_data = sign_ext ? {{(DATA_W-8){sel_byte[7]}}, sel_byte}
                             : {{(DATA_W-8){1'b0}}, sel_byte};
        wdata_rep = {(DATA_W/8){wdata[7:0]}};
        wstrb     = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        load_data = sign_ext ? {{(DATA_W-16){sel_half[15]}}, sel_half}
                             : {{(DATA_W-16){1'b0}}, sel_half};
        wdata_rep = {(DATA_W/16){wdata[15:0]}};
        wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        load_data = rdata;
        wdata_rep = wdata;
        wstrb     = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// Handshaked memory pipeline stage (EMPTY/HOLD/MEM_WAIT).
// Define MEM_TIMEOUT_EN to add a bus watchdog that aborts a stuck request and raises bus_err.
module mem_stage_hs #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [DATA_W-1:0] regcData_i,
  input  logic [REG_AW-1:0] regcAddr_i,
  input  logic              regcWr_i,
  input  logic [DATA_W-1:0] memAddr_i,
  input  logic [DATA_W-1:0] memData_i,
  input  logic              memRr_i,
  input  logic              memWr_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] pc_debug_i,
  input  logic [DATA_W-1:0] inst_debug_i,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] regData,
  output logic [REG_AW-1:0] regAddr,
  output logic              regWr,
  output logic [DATA_W-1:0] pc_debug,
  output logic [DATA_W-1:0] inst_debug,
  output logic              mem_regWr,
  output logic [DATA_W-1:0] mem_data,
  output logic [REG_AW-1:0] mem_regAddr,
  output logic              load_pending,
  output logic              bus_err
);
  import mem_stage_pkg::*;

  state_t            state;
  logic [DATA_W-1:0] data_q, addr_q, wdata_q, pc_q, inst_q;
  logic [REG_AW-1:0] rd_q;
  logic [1:0]        size_q;
  logic              wr_q, load_q, store_q, sign_q, supp_q;
  logic              accept, timeout, in_wait;
  logic [DATA_W-1:0] load_data, wdata_rep;
  logic [3:0]        wstrb;

  assign in_wait  = (state == MEM_WAIT);
  assign in_ready = !in_wait;
  assign accept   = in_valid & in_ready & !flush;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             bus_err_q;

  assign timeout = in_wait & !mem_ack & (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign bus_err = bus_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout;
      if (accept)
        wait_cnt <= '0;
      else if (in_wait && !mem_ack)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .addr_lo  (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (sign_q),
    .rdata    (mem_rdata),
    .wdata    (wdata_q),
    .load_data(load_data),
    .wdata_rep(wdata_rep),
    .wstrb    (wstrb)
  );

  // A flushed access still has to finish on the bus; supp_q remembers to drop its result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= EMPTY;
      data_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      inst_q  <= '0;
      rd_q    <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      sign_q  <= 1'b0;
      supp_q  <= 1'b0;
    end else begin
      case (state)
        EMPTY, HOLD: begin
          if (accept) begin
            data_q  <= regcData_i;
            rd_q    <= regcAddr_i;
            wr_q    <= regcWr_i;
            addr_q  <= memAddr_i;
            wdata_q <= memData_i;
            load_q  <= memRr_i;
            store_q <= memWr_i;
            size_q  <= size_i;
            sign_q  <= signed_i;
            pc_q    <= pc_debug_i;
            inst_q  <= inst_debug_i;
            supp_q  <= 1'b0;
            state   <= (memRr_i | memWr_i) ? MEM_WAIT : HOLD;
          end else begin
            state <= EMPTY;
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            if (load_q && !(supp_q || flush))
              data_q <= load_data;
            if (flush)
              wr_q <= 1'b0;
            state <= (supp_q || flush) ? EMPTY : HOLD;
          end else if (timeout) begin
            wr_q  <= 1'b0;
            state <= (supp_q || flush) ? EMPTY : HOLD;
          end else if (flush) begin
            supp_q <= 1'b1;
            wr_q   <= 1'b0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign mem_req      = in_wait;
  assign mem_we       = in_wait & store_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_rep;
  assign mem_wstrb    = in_wait ? wstrb : 4'b0000;
  assign wb_valid     = (state == HOLD);
  assign regData      = data_q;
  assign regAddr      = rd_q;
  assign regWr        = wr_q;
  assign pc_debug     = pc_q;
  assign inst_debug   = inst_q;
  assign mem_regWr    = wr_q & (state == HOLD);
  assign mem_data     = data_q;
  assign mem_regAddr  = rd_q;
  assign load_pending = in_wait & load_q & wr_q & !supp_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed self-checking bench for mem_stage_hs; timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_stage_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush;
  logic [31:0] regcData_i;
  logic [4:0]  regcAddr_i;
  logic        regcWr_i;
  logic [31:0] memAddr_i, memData_i;
  logic        memRr_i, memWr_i;
  logic [1:0]  size_i;
  logic        signed_i;
  logic [31:0] pc_debug_i, inst_debug_i;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [31:0] regData;
  logic [4:0]  regAddr;
  logic        regWr;
  logic [31:0] pc_debug, inst_debug;
  logic        mem_regWr;
  logic [31:0] mem_data;
  logic [4:0]  mem_regAddr;
  logic        load_pending, bus_err;

  int testsRun = 0;
  int testsFailed = 0;

  mem_stage_hs #(.DATA_W(32), .REG_AW(5), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .regcData_i(regcData_i), .regcAddr_i(regcAddr_i), .regcWr_i(regcWr_i),
    .memAddr_i(memAddr_i), .memData_i(memData_i), .memRr_i(memRr_i), .memWr_i(memWr_i),
    .size_i(size_i), .signed_i(signed_i), .pc_debug_i(pc_debug_i), .inst_debug_i(inst_debug_i),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .regData(regData), .regAddr(regAddr), .regWr(regWr),
    .pc_debug(pc_debug), .inst_debug(inst_debug),
    .mem_regWr(mem_regWr), .mem_data(mem_data), .mem_regAddr(mem_regAddr),
    .load_pending(load_pending), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic rr, input logic wr, input logic [1:0] sz,
                               input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] rc, input logic [4:0] ra, input logic rw);
    in_valid     = v;
    memRr_i      = rr;
    memWr_i      = wr;
    size_i       = sz;
    signed_i     = sg;
    memAddr_i    = addr;
    memData_i    = wd;
    regcData_i   = rc;
    regcAddr_i   = ra;
    regcWr_i     = rw;
    pc_debug_i   = 32'h0000_1000 + rc;
    inst_debug_i = ~rc;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  logic [31:0] stAddr [2] = '{32'h0000_0101, 32'h0000_0107};
  logic [31:0] stData [2] = '{32'h1234_565A, 32'h1357_9BDF};
  logic [1:0]  stSize [2] = '{2'd0, 2'd2};
  logic [3:0]  stStrb [2] = '{4'b0010, 4'b1111};
  logic [31:0] stWdat [2] = '{32'h5A5A_5A5A, 32'h1357_9BDF};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] bench did not finish");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    idle();
    step(); step();
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_regData", regData, 0);
    checkOutput("rst_regWr", regWr, 0);
    checkOutput("rst_wstrb", mem_wstrb, 0);
    checkOutput("rst_load_pending", load_pending, 0);
    rst = 1'b1;
    step();

    applyStimulus(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1);
    step();
    idle();
    checkOutput("alu_wb_valid", wb_valid, 1);
    checkOutput("alu_regData", regData, 32'h1234);
    checkOutput("alu_regAddr", regAddr, 5);
    checkOutput("alu_regWr", regWr, 1);
    checkOutput("alu_mem_regWr", mem_regWr, 1);
    checkOutput("alu_pc_debug", pc_debug, 32'h2234);
    checkOutput("alu_mem_req", mem_req, 0);
    step();
    checkOutput("alu_wb_pulse", wb_valid, 0);
    checkOutput("alu_mem_req_after", mem_req, 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h11, 5'd1, 1'b1);
    step();
    checkOutput("b2b_first", regData, 32'h11);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h22, 5'd2, 1'b1);
    step();
    idle();
    checkOutput("b2b_wb_valid", wb_valid, 1);
    checkOutput("b2b_second", regData, 32'h22);
    checkOutput("b2b_regAddr", regAddr, 2);
    step();

    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h0, 5'd7, 1'b1);
    step();
    idle();
    checkOutput("lb_addr", mem_addr, 32'h103);
    checkOutput("lb_we", mem_we, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("lb_in_ready", in_ready, 0);
      checkOutput("lb_pending", load_pending, 1);
      checkOutput("lb_req", mem_req, 1);
      if (i == 3) begin
        mem_ack = 1'b1;
        mem_rdata = 32'h80FF_FFFF;
      end
      step();
    end
    mem_ack = 1'b0; mem_rdata = 32'h0;
    checkOutput("lb_wb_valid", wb_valid, 1);
    checkOutput("lb_regData", regData, 32'hFFFF_FF80);
    checkOutput("lb_regWr", regWr, 1);
    checkOutput("lb_pending_done", load_pending, 0);
    checkOutput("lb_req_low", mem_req, 0);
    checkOutput("lb_in_ready_back", in_ready, 1);
    step();
    checkOutput("lb_wb_pulse", wb_valid, 0);

    applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h0, 5'd8, 1'b1);
    step();
    idle();
    mem_ack = 1'b1; mem_rdata = 32'h8001_1234;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    checkOutput("lhu_regData", regData, 32'h0000_8001);
    step();

    applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'hFFFF_ABCD, 32'h0, 5'd0, 1'b0);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      checkOutput("sh_we", mem_we, 1);
      checkOutput("sh_wstrb", mem_wstrb, 4'b1100);
      checkOutput("sh_wdata", mem_wdata, 32'hABCD_ABCD);
      checkOutput("sh_addr", mem_addr, 32'h102);
      if (i == 2) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    checkOutput("sh_wb_valid", wb_valid, 1);
    checkOutput("sh_regWr", regWr, 0);
    checkOutput("sh_req_low", mem_req, 0);
    step();

    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, stSize[k], 1'b0, stAddr[k], stData[k], 32'h0, 5'd0, 1'b0);
      step();
      idle();
      checkOutput("st_wstrb", mem_wstrb, stStrb[k]);
      checkOutput("st_wdata", mem_wdata, stWdat[k]);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      step();
    end

    applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h0, 5'd9, 1'b1);
    step();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("fl_req_kept", mem_req, 1);
    checkOutput("fl_pending", load_pending, 0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    checkOutput("fl_wb_valid", wb_valid, 0);
    checkOutput("fl_regWr", regWr, 0);
    checkOutput("fl_req_low", mem_req, 0);
    checkOutput("fl_in_ready", in_ready, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h55, 5'd3, 1'b1);
    step();
    idle();
    checkOutput("fl_next_wb", wb_valid, 1);
    checkOutput("fl_next_data", regData, 32'h55);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h66, 5'd4, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    checkOutput("fl_wins_wb", wb_valid, 0);

    applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, 5'd10, 1'b1);
    step();
    idle();
    checkOutput("rmw_req", mem_req, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    checkOutput("rmw_req_low", mem_req, 0);
    checkOutput("rmw_in_ready", in_ready, 1);
    checkOutput("rmw_addr", mem_addr, 0);
    checkOutput("rmw_pending", load_pending, 0);
    checkOutput("rmw_regWr", regWr, 0);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    mem_ack = 1'b0;
    checkOutput("rmw_late_ack_wb", wb_valid, 0);
    checkOutput("rmw_late_ack_data", regData, 0);

`ifdef MEM_TIMEOUT_EN
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h0, 5'd11, 1'b1);
    step();
    idle();
    for (int i = 0; i < 8; i++) begin
      checkOutput("to_req", mem_req, 1);
      checkOutput("to_no_err", bus_err, 0);
      step();
    end
    checkOutput("to_req_low", mem_req, 0);
    checkOutput("to_bus_err", bus_err, 1);
    checkOutput("to_regWr", regWr, 0);
    step();
    checkOutput("to_err_pulse", bus_err, 0);
`else
    checkOutput("bus_err_tied", bus_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
